lin_resp_rx: RTL

//  Serial receiver downstream of the LIN responder. Samples the responder's idle-high serial output and deframes it.

---
 rtl/lin_pkg.sv | 20 ++
 rtl/lin_resp_rx_crc.sv | 20 ++
 rtl/lin_resp_rx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lin_pkg.sv
// Shared encodings and frame constants for the LIN response receiver.
package lin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_CHK = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_GAP       = 3'd4,
    ST_DONE      = 3'd5,
    ST_RESYNC    = 3'd6
  } lin_state_e;

  localparam logic [7:0] LIN_CRC_INIT      = 8'hFF;
  localparam logic [7:0] LIN_CRC_POLY      = 8'h1D;
  localparam int         LIN_BITS_PER_BYTE = 10;
  localparam int         LIN_DATA_BYTES    = 8;
  localparam int         LIN_FRAME_BYTES   = 9;

endpackage

// File: rtl/lin_resp_rx_crc.sv
// Combinational CRC-8 (poly 0x1D, non-reflected) over a 64-bit word, bit 63 first.
module crcd64_o8
  import lin_pkg::*;
(
  input  logic [7:0]  crc_in,
  input  logic [63:0] data_in,
  output logic [7:0]  crc_out
);

  logic [7:0] crc_v;

  always_comb begin
    crc_v = crc_in;
    for (int i = 63; i >= 0; i--) begin
      crc_v = {crc_v[6:0], 1'b0} ^ ((crc_v[7] ^ data_in[i]) ? LIN_CRC_POLY : 8'h00);
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/lin_resp_rx.sv
// Deframes the responder's serial stream (8 data bytes + checksum byte, UART-style
// framing) and reports payload, checksum and framing/gap/checksum status.
module lin_resp_rx
  import lin_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_TIMEOUT  = 16
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        sdi,
  output logic [63:0] rx_data,
  output logic [7:0]  rx_checksum,
  output logic        rx_done,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        chk_err,
  output logic [3:0]  rx_bytes,
  output logic        rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int GW   = $clog2(GAP_TIMEOUT + 2);

  localparam logic [CW-1:0] CNT_BIT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_TIMEOUT);

  lin_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [63:0]   payload_q, payload_d;
  logic [7:0]    chk_q, chk_d;

  logic [63:0]   rx_data_q, rx_data_d;
  logic [7:0]    rx_checksum_q, rx_checksum_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic          chk_err_q, chk_err_d;
  logic [3:0]    rx_bytes_q, rx_bytes_d;
  logic          rx_busy_q, rx_busy_d;

  logic          begin_byte;
  logic          abort;
  logic [7:0]    crc_calc;

  crcd64_o8 u_crc (
    .crc_in  (LIN_CRC_INIT),
    .data_in (payload_q),
    .crc_out (crc_calc)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      shift_q       <= '0;
      payload_q     <= '0;
      chk_q         <= '0;
      rx_data_q     <= '0;
      rx_checksum_q <= '0;
      rx_done_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      chk_err_q     <= 1'b0;
      rx_bytes_q    <= '0;
      rx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      shift_q       <= shift_d;
      payload_q     <= payload_d;
      chk_q         <= chk_d;
      rx_data_q     <= rx_data_d;
      rx_checksum_q <= rx_checksum_d;
      rx_done_q     <= rx_done_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      chk_err_q     <= chk_err_d;
      rx_bytes_q    <= rx_bytes_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    shift_d       = shift_q;
    payload_d     = payload_q;
    chk_d         = chk_q;
    rx_data_d     = rx_data_q;
    rx_checksum_d = rx_checksum_q;
    rx_done_d     = 1'b0;
    frame_err_d   = frame_err_q;
    timeout_err_d = timeout_err_q;
    chk_err_d     = chk_err_q;
    rx_bytes_d    = rx_bytes_q;
    rx_busy_d     = rx_busy_q;
    begin_byte    = 1'b0;
    abort         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!sdi) begin
          begin_byte    = 1'b1;
          rx_busy_d     = 1'b1;
          frame_err_d   = 1'b0;
          timeout_err_d = 1'b0;
          chk_err_d     = 1'b0;
          rx_bytes_d    = '0;
          byte_cnt_d    = '0;
          gap_cnt_d     = '0;
          payload_d     = '0;
          chk_d         = '0;
        end
      end

      ST_START_CHK: begin
        if (cnt_q == '0) begin
          if (sdi) begin
            // Line went back high before mid-start: treat as noise, not an error.
            if (byte_cnt_q == '0) begin
              state_d   = ST_IDLE;
              rx_busy_d = 1'b0;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            state_d = ST_DATA;
            cnt_d   = CNT_BIT;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sdi, shift_q[7:1]};
          cnt_d   = CNT_BIT;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!sdi) begin
            frame_err_d = 1'b1;
            abort       = 1'b1;
          end else if (byte_cnt_q == 4'(LIN_DATA_BYTES)) begin
            chk_d   = shift_q;
            state_d = ST_DONE;
          end else begin
            payload_d[8*byte_cnt_q[2:0] +: 8] = shift_q;
            byte_cnt_d = byte_cnt_q + 4'd1;
            gap_cnt_d  = '0;
            state_d    = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_GAP: begin
        if (!sdi) begin
          begin_byte = 1'b1;
        end else if (gap_cnt_q == GAP_LIMIT) begin
          gap_cnt_d     = GAP_LIMIT + GW'(1);
          timeout_err_d = 1'b1;
          abort         = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      ST_DONE: begin
        rx_done_d     = 1'b1;
        rx_busy_d     = 1'b0;
        rx_data_d     = payload_q;
        rx_checksum_d = chk_q;
        rx_bytes_d    = 4'(LIN_FRAME_BYTES);
        chk_err_d     = (crc_calc != chk_q);
        state_d       = ST_IDLE;
      end

      ST_RESYNC: begin
        // A line stuck low after an abort must not be mistaken for a new start.
        if (sdi) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (begin_byte) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      if (HALF == 0) begin
        state_d = ST_DATA;
        cnt_d   = CNT_BIT;
      end else begin
        state_d = ST_START_CHK;
        cnt_d   = CNT_HALF;
      end
    end

    if (abort) begin
      rx_done_d     = 1'b1;
      rx_busy_d     = 1'b0;
      rx_data_d     = payload_q;
      rx_checksum_d = chk_q;
      rx_bytes_d    = byte_cnt_q;
      chk_err_d     = 1'b0;
      state_d       = ST_RESYNC;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_checksum = rx_checksum_q;
  assign rx_done     = rx_done_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign chk_err     = chk_err_q;
  assign rx_bytes    = rx_bytes_q;
  assign rx_busy     = rx_busy_q;

endmodule
